keypad_scanner: RTL and testbench

Column-scanning reader for a 4x4 matrix keypad. It drives one column low at a time in rotation, samples the four row lines, and debounces across whole scans. It reports one stable key as a 4-bit code with a single-cycle press strobe. It is the input-side counterpart of the seven-segment anode multiplexer and sits between the keypad header pins and the display/control logic.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_scanner_scan_timer.sv | 38 +++
 rtl/keypad_scanner.sv | 145 ++++++++++++++
 tb/tb_keypad_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } scan_res_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HELD = 1'b1
   } key_state_e;

   localparam logic [3:0] KEY_COL_RST = 4'b1110;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      logic [2:0] n;
      n = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   // Index of the lowest set bit; only meaningful when exactly one bit is set.
   function automatic logic [1:0] bit_index4(input logic [3:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (v[3-i]) idx = 2'(3 - i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// Column dwell timer: settle counter plus 2-bit column counter with a sample strobe.
module scan_timer #(
   parameter int unsigned SETTLE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] col_o,
   output logic       sample_en_o
);

   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic [CW-1:0] settle_q, settle_d;
   logic [1:0]    col_q, col_d;

   assign sample_en_o = (settle_q == CW'(SETTLE_CYCLES - 1));
   assign col_o       = col_q;

   always_comb begin
      settle_d = settle_q + 1'b1;
      col_d    = col_q;
      if (sample_en_o) begin
         settle_d = '0;
         col_d    = col_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_q <= '0;
         col_q    <= '0;
      end else begin
         settle_q <= settle_d;
         col_q    <= col_d;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the driven column, classifies each full
// scan and debounces across scans before reporting a single held key.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] KEY_ROW,
   output logic [3:0] KEY_COL,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned MW = $clog2(DEBOUNCE_SCANS + 1);

   logic [1:0]  col;
   logic        sample_en;

   logic [3:0]  row_s1_q, row_s2_q;
   logic [3:0]  rows_act;
   logic [3:0]  key_col_q, key_col_d;
   logic [1:0]  acc_cnt_q, acc_cnt_d;
   logic [3:0]  acc_code_q, acc_code_d;
   scan_res_e   prev_res_q, prev_res_d;
   logic [3:0]  prev_code_q, prev_code_d;
   logic [MW-1:0] match_q, match_d;
   key_state_e  state_q, state_d;
   logic [3:0]  code_q, code_d;
   logic        valid_q, valid_d;

   logic [2:0]  nbits;
   logic [2:0]  acc_sum;
   logic [1:0]  acc_cnt_new;
   logic [3:0]  code_new;
   scan_res_e   res;
   logic        same;
   logic        reached;

   scan_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_scan_timer (
      .clk        (clk),
      .rst        (rst),
      .col_o      (col),
      .sample_en_o(sample_en)
   );

   assign rows_act = ~row_s2_q;

   always_comb begin
      key_col_d   = key_col_q;
      acc_cnt_d   = acc_cnt_q;
      acc_code_d  = acc_code_q;
      prev_res_d  = prev_res_q;
      prev_code_d = prev_code_q;
      match_d     = match_q;
      state_d     = state_q;
      code_d      = code_q;
      valid_d     = 1'b0;
      same        = 1'b0;
      reached     = 1'b0;

      // Bit count saturates at 2: anything beyond one pressed switch is MULTI.
      nbits       = popcount4(rows_act);
      acc_sum     = {1'b0, acc_cnt_q} + nbits;
      acc_cnt_new = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
      code_new    = acc_code_q;
      if (acc_cnt_q == 2'd0 && nbits == 3'd1) code_new = {col, bit_index4(rows_act)};

      res = NONE;
      if (acc_cnt_new == 2'd1)      res = SINGLE;
      else if (acc_cnt_new == 2'd2) res = MULTI;

      if (sample_en) begin
         key_col_d = ~(4'b0001 << (col + 2'd1));
         if (col != 2'd3) begin
            acc_cnt_d  = acc_cnt_new;
            acc_code_d = code_new;
         end else begin
            acc_cnt_d   = '0;
            acc_code_d  = '0;
            same        = (res == prev_res_q) && (res != SINGLE || code_new == prev_code_q);
            match_d     = same ? ((match_q == MW'(DEBOUNCE_SCANS)) ? match_q : match_q + 1'b1)
                               : MW'(1);
            // Only the scan that brings the run up to the target acts; a
            // saturated run must be broken before another press is accepted.
            reached     = (match_d == MW'(DEBOUNCE_SCANS)) &&
                          !(same && match_q == MW'(DEBOUNCE_SCANS));
            prev_res_d  = res;
            prev_code_d = code_new;
            if (reached) begin
               case (state_q)
                  IDLE: if (res == SINGLE) begin
                     state_d = HELD;
                     code_d  = code_new;
                     valid_d = 1'b1;
                  end
                  HELD: if (res == NONE || (res == SINGLE && code_new != code_q)) begin
                     state_d = IDLE;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1_q    <= '1;
         row_s2_q    <= '1;
         key_col_q   <= KEY_COL_RST;
         acc_cnt_q   <= '0;
         acc_code_q  <= '0;
         prev_res_q  <= NONE;
         prev_code_q <= '0;
         match_q     <= '0;
         state_q     <= IDLE;
         code_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         row_s1_q    <= KEY_ROW;
         row_s2_q    <= row_s1_q;
         key_col_q   <= key_col_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_code_q  <= acc_code_d;
         prev_res_q  <= prev_res_d;
         prev_code_q <= prev_code_d;
         match_q     <= match_d;
         state_q     <= state_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
      end
   end

   assign KEY_COL   = key_col_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = (state_q == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: switch-matrix keypad model plus a scan-level reference model.
module tb_keypad_scanner;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] sw = '0;   // sw[c*4+r]: switch between column c and row r closed

   int errors = 0;
   int checks = 0;

   keypad_scanner #(
      .SETTLE_CYCLES (SETTLE),
      .DEBOUNCE_SCANS(DEB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .KEY_ROW  (key_row),
      .KEY_COL  (key_col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   always_comb begin
      key_row = '1;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (sw[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: time-indexed cycles since reset, whole-scan results.
   int          t;
   logic [15:0] hist [4];
   logic [3:0]  samp [4];
   int          run_len;
   int          prev_kind;
   logic [3:0]  prev_code;
   bit          exp_held;
   logic [3:0]  exp_code;
   bit          exp_valid;
   bit          live = 0;
   int          vcount;

   task automatic model_reset();
      t = 0; run_len = 0; prev_kind = 0; prev_code = '0;
      exp_held = 0; exp_code = '0; exp_valid = 0;
   endtask

   task automatic model_scan_end();
      int         nb;
      int         kind;
      logic [3:0] code;
      bit         same;
      nb = 0; code = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (samp[c][r]) begin
               nb++;
               code = 4'(c*4 + r);
            end
      kind = (nb == 0) ? 0 : (nb == 1) ? 1 : 2;
      same = (kind == prev_kind) && (kind != 1 || code == prev_code);
      run_len = same ? run_len + 1 : 1;
      prev_kind = kind; prev_code = code;
      if (run_len == DEB) begin
         if (!exp_held && kind == 1) begin
            exp_held = 1; exp_code = code; exp_valid = 1;
         end else if (exp_held && (kind == 0 || (kind == 1 && code != exp_code))) begin
            exp_held = 0;
         end
      end
   endtask

   task automatic tick();
      logic [3:0] exp_col;
      logic [3:0] one;
      hist[t % 4] = sw;
      @(posedge clk);
      exp_valid = 0;
      if (rst) begin
         model_reset();
      end else begin
         if (t % SETTLE == SETTLE - 1) begin
            int col;
            logic [15:0] seen;
            col  = (t / SETTLE) % 4;
            seen = hist[(t + 2) % 4];
            samp[col] = seen[col*4 +: 4];
            if (col == 3) model_scan_end();
         end
         t++;
      end
      #1;
      if (!rst && live) begin
         one = 4'b0001 << ((t / SETTLE) % 4);
         exp_col = ~one;
         check_eq("KEY_COL", key_col, exp_col);
         check_eq("key_held", key_held, exp_held);
         check_eq("key_valid", key_valid, exp_valid);
         check_eq("key_code", key_code, exp_code);
         if (key_valid) vcount++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      bit found;
      model_reset();
      for (int i = 0; i < 4; i++) hist[i] = '0;
      for (int i = 0; i < 4; i++) samp[i] = '0;

      // Reset and idle scanning
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      live = 1;
      check_eq("rst_col", key_col, 4'b1110);
      check_eq("rst_held", key_held, 1'b0);
      check_eq("rst_valid", key_valid, 1'b0);
      check_eq("rst_code", key_code, 4'h0);
      vcount = 0;
      run(200);
      check_eq("idle_pulses", vcount, 0);

      // Single stable press: col 2, row 1
      vcount = 0;
      sw[9] = 1'b1;
      run(3 + 4*16);
      check_eq("press_pulses", vcount, 1);
      check_eq("press_code", key_code, 4'b1001);
      check_eq("press_held", key_held, 1'b1);
      run(40);
      check_eq("press_once", vcount, 1);

      // Release
      vcount = 0;
      sw = '0;
      run(80);
      check_eq("rel_held", key_held, 1'b0);
      check_eq("rel_code", key_code, 4'b1001);
      check_eq("rel_pulses", vcount, 0);

      // Bouncy press
      vcount = 0;
      sw[9] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0 && i % 5 == 0) sw[9] = ~sw[9];
         tick();
      end
      check_eq("bounce_quiet", vcount, 0);
      sw[9] = 1'b1;
      run(90);
      check_eq("bounce_pulses", vcount, 1);
      check_eq("bounce_code", key_code, 4'b1001);
      sw = '0;
      run(80);

      // Two keys together, then release one
      vcount = 0;
      sw[0] = 1'b1; sw[15] = 1'b1;
      run(80);
      check_eq("multi_pulses", vcount, 0);
      check_eq("multi_held", key_held, 1'b0);
      sw[15] = 1'b0;
      run(80);
      check_eq("multi_rel_pulses", vcount, 1);
      check_eq("multi_rel_code", key_code, 4'b0000);
      check_eq("multi_rel_held", key_held, 1'b1);

      // Reset while column 2 is driven with a key held
      found = 0;
      for (int i = 0; i < 32 && !found; i++) begin
         tick();
         if ((t / SETTLE) % 4 == 2) found = 1;
      end
      check_eq("wait_col2", found, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check_eq("mid_rst_col", key_col, 4'b1110);
      check_eq("mid_rst_held", key_held, 1'b0);
      vcount = 0;
      run(80);
      check_eq("mid_rst_pulses", vcount, 1);
      check_eq("mid_rst_code", key_code, 4'b0000);

      // Randomized key patterns with occasional one-cycle glitches
      for (int seg = 0; seg < 30; seg++) begin
         int k;
         int len;
         sw = '0;
         k = $urandom_range(0, 9);
         if (k >= 3) sw[$urandom_range(0, 15)] = 1'b1;
         if (k >= 8) sw[$urandom_range(0, 15)] = 1'b1;
         len = $urandom_range(8, 90);
         for (int i = 0; i < len; i++) begin
            logic [15:0] save;
            save = sw;
            if ($urandom_range(0, 39) == 0) sw[$urandom_range(0, 15)] ^= 1'b1;
            tick();
            sw = save;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
